// File: rtl/flash_loader_if.sv
// Flash-side (flash_ctrl handshake) and RAM-side (req/ack write port) signals of the boot loader.
// The loader side is the master; the flash controller and RAM side is the slave.
interface flash_loader_if #(
    parameter int FA_W = 22,
    parameter int RA_W = 20
);
    logic [FA_W-1:0] fl_addr;
    logic            fl_read;
    logic            fl_ready;
    logic [15:0]     fl_data;
    logic [RA_W-1:0] ram_addr;
    logic [15:0]     ram_wdata;
    logic            ram_we;
    logic            ram_ack;

    modport master (
        output fl_addr, fl_read, ram_addr, ram_wdata, ram_we,
        input  fl_ready, fl_data, ram_ack
    );

    modport slave (
        input  fl_addr, fl_read, ram_addr, ram_wdata, ram_we,
        output fl_ready, fl_data, ram_ack
    );
endinterface

// File: rtl/flash_loader.sv
// Boot-copy sequencer: reads word_count 16-bit words from NOR flash via flash_ctrl
// and writes each one into RAM through a req/ack port, with a per-word timeout.
module flash_loader #(
    parameter int FA_W      = 22,
    parameter int RA_W      = 20,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [FA_W-1:0]  i_flash_base,
    input  logic [RA_W-1:0]  i_ram_base,
    input  logic [CNT_W-1:0] i_word_count,
    flash_loader_if.master   bus,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error,
    output logic [CNT_W-1:0] o_words_done,
    output logic [3:0]       o_state
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_ISSUE   = 4'd1,
        S_WAIT_LO = 4'd2,
        S_WAIT_HI = 4'd3,
        S_WRITE   = 4'd4,
        S_DONE    = 4'd5,
        S_ERR     = 4'd6
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [FA_W-1:0]      r_fl_addr;
    logic [RA_W-1:0]      r_ram_addr;
    logic [15:0]          r_wdata;
    logic [CNT_W-1:0]     r_count;
    logic [CNT_W-1:0]     r_words;
    logic [TIMEOUT_W-1:0] r_tmo;
    logic                 r_error;

    logic                 w_accept;
    logic                 w_timeout;
    logic                 w_last;
    logic [CNT_W-1:0]     w_words_inc;

    // A new job may be launched from IDLE or as a retry out of ERR.
    assign w_accept    = i_start && ((r_state == S_IDLE) || (r_state == S_ERR));
    assign w_timeout   = &r_tmo;
    assign w_words_inc = r_words + CNT_W'(1);
    assign w_last      = (w_words_inc == r_count);

    assign bus.fl_addr   = r_fl_addr;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wdata = r_wdata;
    assign o_error       = r_error;
    assign o_words_done  = r_words;
    assign o_state       = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        bus.fl_read = 1'b0;
        bus.ram_we  = 1'b0;
        o_busy      = 1'b1;
        o_done      = 1'b0;
        case (r_state)
            S_IDLE, S_ERR: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_next = (i_word_count == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus.fl_read = 1'b1;
                w_next      = S_WAIT_LO;
            end
            // Ready must drop first so a ready=1 left over from the previous word is not taken as data.
            S_WAIT_LO: begin
                if (!bus.fl_ready) begin
                    w_next = S_WAIT_HI;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_WAIT_HI: begin
                if (bus.fl_ready) begin
                    w_next = S_WRITE;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_WRITE: begin
                bus.ram_we = 1'b1;
                if (bus.ram_ack) begin
                    w_next = w_last ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                o_busy = 1'b0;
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                o_busy = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fl_addr  <= '0;
            r_ram_addr <= '0;
            r_wdata    <= '0;
            r_count    <= '0;
            r_words    <= '0;
            r_tmo      <= '0;
            r_error    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_fl_addr  <= i_flash_base;
                r_ram_addr <= i_ram_base;
                r_count    <= i_word_count;
                r_words    <= '0;
                r_error    <= 1'b0;
            end
            if (r_state == S_ISSUE) begin
                r_tmo <= '0;
            end else if ((r_state == S_WAIT_LO) || (r_state == S_WAIT_HI)) begin
                r_tmo <= r_tmo + TIMEOUT_W'(1);
            end
            if ((r_state == S_WAIT_HI) && bus.fl_ready) begin
                r_wdata <= bus.fl_data;
            end
            // Addresses wrap silently at their widths.
            if ((r_state == S_WRITE) && bus.ram_ack) begin
                r_words    <= w_words_inc;
                r_fl_addr  <= r_fl_addr + FA_W'(1);
                r_ram_addr <= r_ram_addr + RA_W'(1);
            end
            if ((w_next == S_ERR) && (r_state != S_ERR)) begin
                r_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flash_loader.sv
// Directed bench for flash_loader with a behavioural flash_ctrl (data = addr ^ 0xA5A5)
// and a RAM port whose acknowledge latency is adjustable.
module tb_flash_loader;

    localparam int FA_W      = 22;
    localparam int RA_W      = 20;
    localparam int CNT_W     = 16;
    localparam int TIMEOUT_W = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [FA_W-1:0]  flashBase = '0;
    logic [RA_W-1:0]  ramBase = '0;
    logic [CNT_W-1:0] wordCount = '0;
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] wordsDone;
    logic [3:0]       state;

    int compares = 0;
    int mismatches = 0;

    flash_loader_if #(.FA_W(FA_W), .RA_W(RA_W)) bus();

    flash_loader #(
        .FA_W(FA_W), .RA_W(RA_W), .CNT_W(CNT_W), .TIMEOUT_W(TIMEOUT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_start(start),
        .i_flash_base(flashBase),
        .i_ram_base(ramBase),
        .i_word_count(wordCount),
        .bus(bus),
        .o_busy(busy),
        .o_done(done),
        .o_error(error),
        .o_words_done(wordsDone),
        .o_state(state)
    );

    always #5 clk = ~clk;

    // Model knobs, written only by the stimulus process.
    bit flNever = 1'b0;
    int staleHi = 0;
    int lowLen = 2;
    int ackDelay = 0;

    // Monitors, written only by the model processes.
    int flReads = 0;
    int ramWrites = 0;
    int doneCount = 0;
    int weCycles = 0;
    int waitCycles = 0;
    int unstable = 0;
    logic [RA_W-1:0] lastRamAddr = '0;
    logic [15:0]     ramMem [0:255];

    int              flT = 0;
    logic [FA_W-1:0] flA = '0;

    // Flash controller: optional stale-high window, then low, then high with data.
    always @(posedge clk) begin
        if (bus.fl_read) begin
            flT = 1;
            flA = bus.fl_addr;
            flReads++;
        end else if (flT != 0) begin
            flT++;
        end
        if (flT == 0) begin
            bus.fl_ready <= 1'b1;
            bus.fl_data  <= 16'h0000;
        end else if (flNever) begin
            bus.fl_ready <= 1'b0;
        end else if (flT <= staleHi) begin
            bus.fl_ready <= 1'b1;
            bus.fl_data  <= 16'hDEAD;
        end else if (flT <= staleHi + lowLen) begin
            bus.fl_ready <= 1'b0;
        end else begin
            bus.fl_ready <= 1'b1;
            bus.fl_data  <= flA[15:0] ^ 16'hA5A5;
        end
    end

    int              weCnt = 0;
    logic            prevWe = 1'b0;
    logic [RA_W-1:0] prevAddr = '0;
    logic [15:0]     prevData = '0;

    // RAM port: acknowledges after ackDelay extra cycles of held request.
    always @(posedge clk) begin
        if (bus.ram_we) weCycles++;
        if (bus.ram_we && prevWe && ((bus.ram_addr != prevAddr) || (bus.ram_wdata != prevData))) unstable++;
        prevWe   = bus.ram_we;
        prevAddr = bus.ram_addr;
        prevData = bus.ram_wdata;
        if (bus.ram_we && bus.ram_ack) begin
            ramMem[bus.ram_addr[7:0]] = bus.ram_wdata;
            lastRamAddr = bus.ram_addr;
            ramWrites++;
            weCnt = 0;
            bus.ram_ack <= 1'b0;
        end else if (bus.ram_we) begin
            if (weCnt >= ackDelay) bus.ram_ack <= 1'b1;
            else weCnt++;
        end else begin
            weCnt = 0;
            bus.ram_ack <= 1'b0;
        end
        if (done) doneCount++;
        if ((state == 4'd2) || (state == 4'd3)) waitCycles++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compares++;
        if (observed !== expected) begin
            mismatches++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [FA_W-1:0] fb, input logic [RA_W-1:0] rb, input logic [CNT_W-1:0] cnt);
        @(negedge clk);
        flashBase = fb;
        ramBase   = rb;
        wordCount = cnt;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic waitEvent(input string tag, input int limit, input bit forError, output int cycles);
        cycles = 0;
        while (cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (forError ? error : done) break;
        end
        checkOutput(tag, forError ? error : done, 1);
    endtask

    task automatic checkReset(input string p);
        checkOutput({p, "State"},    state, 0);
        checkOutput({p, "Busy"},     busy, 0);
        checkOutput({p, "Done"},     done, 0);
        checkOutput({p, "Error"},    error, 0);
        checkOutput({p, "Words"},    wordsDone, 0);
        checkOutput({p, "FlAddr"},   bus.fl_addr, 0);
        checkOutput({p, "FlRead"},   bus.fl_read, 0);
        checkOutput({p, "RamAddr"},  bus.ram_addr, 0);
        checkOutput({p, "RamWdata"}, bus.ram_wdata, 0);
        checkOutput({p, "RamWe"},    bus.ram_we, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int r0, w0, d0, we0, wt0, u0;

        repeat (3) @(negedge clk);
        checkReset("rstHeld");
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idleAfterRst", state, 0);

        $display("[TB] three-word copy, 0x100 -> 0x40");
        r0 = flReads; w0 = ramWrites; d0 = doneCount;
        applyStimulus(22'h000100, 20'h00040, 16'd3);
        checkOutput("t1Busy", busy, 1);
        checkOutput("t1Read", bus.fl_read, 1);
        checkOutput("t1FlAddr", bus.fl_addr, 32'h100);
        waitEvent("t1Done", 300, 1'b0, cyc);
        repeat (2) @(negedge clk);
        checkOutput("t1Mem40", ramMem[8'h40], 32'hA4A5);
        checkOutput("t1Mem41", ramMem[8'h41], 32'hA4A4);
        checkOutput("t1Mem42", ramMem[8'h42], 32'hA4A7);
        checkOutput("t1Reads", flReads - r0, 3);
        checkOutput("t1Writes", ramWrites - w0, 3);
        checkOutput("t1DoneCount", doneCount - d0, 1);
        checkOutput("t1Words", wordsDone, 3);
        checkOutput("t1Idle", state, 0);
        checkOutput("t1NotBusy", busy, 0);

        $display("[TB] zero-length job");
        r0 = flReads; we0 = weCycles;
        applyStimulus(22'h001234, 20'h00055, 16'd0);
        checkOutput("t2DoneNext", done, 1);
        checkOutput("t2NotBusy", busy, 0);
        @(negedge clk);
        checkOutput("t2DoneOnce", done, 0);
        checkOutput("t2Idle", state, 0);
        checkOutput("t2Reads", flReads - r0, 0);
        checkOutput("t2WeCycles", weCycles - we0, 0);

        $display("[TB] slow RAM acknowledge with ignored start while busy");
        ackDelay = 5;
        r0 = flReads; w0 = ramWrites; we0 = weCycles; u0 = unstable;
        applyStimulus(22'h0002A5, 20'h00080, 16'd1);
        for (int i = 0; i < 50 && !bus.ram_we; i++) @(negedge clk);
        checkOutput("t3WeSeen", bus.ram_we, 1);
        flashBase = 22'h000333;
        ramBase   = 20'h00099;
        wordCount = 16'd5;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        waitEvent("t3Done", 200, 1'b0, cyc);
        repeat (2) @(negedge clk);
        checkOutput("t3Writes", ramWrites - w0, 1);
        checkOutput("t3Stable", unstable - u0, 0);
        checkOutput("t3WeHeld", (weCycles - we0) >= 5, 1);
        checkOutput("t3Mem80", ramMem[8'h80], 32'hA700);
        checkOutput("t3LastAddr", lastRamAddr, 32'h80);
        checkOutput("t3Reads", flReads - r0, 1);
        ackDelay = 0;

        $display("[TB] flash never ready -> timeout, then retry");
        flNever = 1'b1;
        r0 = flReads; w0 = ramWrites; wt0 = waitCycles;
        applyStimulus(22'h000010, 20'h00010, 16'd2);
        waitEvent("t4ErrorSeen", 200, 1'b1, cyc);
        checkOutput("t4NotBusy", busy, 0);
        checkOutput("t4State", state, 6);
        checkOutput("t4WaitLen", ((waitCycles - wt0) >= 63) && ((waitCycles - wt0) <= 64), 1);
        checkOutput("t4Writes", ramWrites - w0, 0);
        checkOutput("t4Reads", flReads - r0, 1);
        repeat (3) @(negedge clk);
        checkOutput("t4Sticky", error, 1);
        checkOutput("t4StayErr", state, 6);
        flNever = 1'b0;
        applyStimulus(22'h000010, 20'h00010, 16'd2);
        checkOutput("t4ErrCleared", error, 0);
        checkOutput("t4RetryBusy", busy, 1);
        waitEvent("t4RetryDone", 300, 1'b0, cyc);
        checkOutput("t4Mem10", ramMem[8'h10], 32'hA5B5);
        checkOutput("t4Mem11", ramMem[8'h11], 32'hA5B4);
        checkOutput("t4NoError", error, 0);
        checkOutput("t4Words", wordsDone, 2);

        $display("[TB] stale ready window and address wrap");
        staleHi = 2;
        r0 = flReads;
        applyStimulus(22'h3FFFFF, 20'hFFFFF, 16'd2);
        waitEvent("t5Done", 300, 1'b0, cyc);
        checkOutput("t5MemFF", ramMem[8'hFF], 32'h5A5A);
        checkOutput("t5Mem00", ramMem[8'h00], 32'hA5A5);
        checkOutput("t5LastAddr", lastRamAddr, 0);
        checkOutput("t5FlAddrWrap", bus.fl_addr, 1);
        checkOutput("t5RamAddrWrap", bus.ram_addr, 1);
        checkOutput("t5Reads", flReads - r0, 2);
        staleHi = 0;

        $display("[TB] reset during second word");
        lowLen = 6;
        r0 = flReads;
        applyStimulus(22'h000200, 20'h00020, 16'd3);
        for (int i = 0; i < 200 && !((state == 4'd3) && ((flReads - r0) == 2)); i++) @(negedge clk);
        checkOutput("t6ReachedHi", (state == 4'd3) && ((flReads - r0) == 2), 1);
        rst = 1'b1;
        @(negedge clk);
        checkReset("t6");
        r0 = flReads; we0 = weCycles;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("t6NoReads", flReads - r0, 0);
        checkOutput("t6NoWe", weCycles - we0, 0);
        checkOutput("t6Idle", state, 0);
        lowLen = 2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end

endmodule
